// File: rtl/raw_bus_arb.sv
// raw_bus_arb: round-robin arbiter driving the raw bus register pair write port.
// Optional bus locking is compiled in with `define RAW_BUS_ARB_LOCK_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module raw_bus_arb #(
  parameter int N_REQ    = 4,
  parameter int LOCK_MAX = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_REQ-1:0]             i_req,
  input  logic [2*N_REQ-1:0]           i_target,
  input  logic [N_REQ*`DATA_WIDTH-1:0] i_data,
  input  logic [N_REQ-1:0]             i_lock,
  output logic [N_REQ-1:0]             o_gnt,
  output logic                         o_raw_bus_0_en,
  output logic                         o_raw_bus_1_en,
  output logic [`DATA_WIDTH-1:0]       o_data,
  output logic                         o_busy,
  output logic                         o_lock_timeout
);
  localparam int DW = `DATA_WIDTH;
  localparam int IW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, LOCKED} state_t;
  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_last, w_win, w_sel;
  logic [N_REQ-1:0] w_elig, w_gnt_nxt;
  logic            w_found, w_grant, w_to;
  logic [1:0]      w_tgt;
  logic [DW-1:0]   w_dat;
  int              w_j;
`ifdef RAW_BUS_ARB_LOCK_EN
  logic [IW-1:0]   r_owner;
  logic [7:0]      r_cnt, w_cnt_nxt;
  logic            w_own_req, w_own_lock, w_own_tgt;
  assign w_own_req  = i_req[r_owner];
  assign w_own_lock = i_lock[r_owner];
  assign w_own_tgt  = |i_target[{r_owner, 1'b0} +: 2];
`else
  logic            w_unused_lock;
  assign w_unused_lock = ^i_lock;
`endif
  // A requester granted last cycle is masked so each grant is one transfer.
  always_comb begin
    for (int k = 0; k < N_REQ; k++)
      w_elig[k] = i_req[k] & (|i_target[2*k +: 2]) & ~o_gnt[k];
  end
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_j = int'(r_last) + 1 + i;
      w_j = (w_j >= N_REQ) ? w_j - N_REQ : w_j;
      if (!w_found && w_elig[IW'(w_j)]) begin
        w_found = 1'b1;
        w_win   = IW'(w_j);
      end
    end
  end
  always_comb begin
    w_tgt = '0;
    w_dat = '0;
    for (int k = 0; k < N_REQ; k++)
      if (IW'(k) == w_sel) begin
        w_tgt = i_target[2*k +: 2];
        w_dat = i_data[k*DW +: DW];
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  always_comb begin
    w_state_nxt = w_found ? GRANT : IDLE;
`ifdef RAW_BUS_ARB_LOCK_EN
    if (r_state == LOCKED)
      w_state_nxt = (!w_own_req || !w_own_lock || r_cnt == 8'(LOCK_MAX)) ? IDLE : LOCKED;
    else if (w_found && i_lock[w_win])
      w_state_nxt = LOCKED;
`endif
  end
  always_comb begin
    w_grant = w_found;
    w_sel   = w_win;
    w_to    = 1'b0;
`ifdef RAW_BUS_ARB_LOCK_EN
    w_cnt_nxt = (w_state_nxt == LOCKED) ? 8'd1 : 8'd0;
    if (r_state == LOCKED) begin
      w_sel     = r_owner;
      w_grant   = (w_state_nxt == LOCKED) && w_own_tgt;
      w_to      = w_own_req && w_own_lock && r_cnt == 8'(LOCK_MAX);
      w_cnt_nxt = w_grant ? r_cnt + 8'd1 : r_cnt;
    end
`endif
    w_gnt_nxt = w_grant ? (N_REQ'(1) << w_sel) : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      o_gnt          <= '0;
      o_raw_bus_0_en <= 1'b0;
      o_raw_bus_1_en <= 1'b0;
      o_data         <= '0;
      o_busy         <= 1'b0;
      o_lock_timeout <= 1'b0;
      r_last         <= IW'(N_REQ - 1);
    end else begin
      o_gnt          <= w_gnt_nxt;
      o_raw_bus_0_en <= w_grant & w_tgt[0];
      o_raw_bus_1_en <= w_grant & w_tgt[1];
      o_data         <= w_grant ? w_dat : o_data;
      o_busy         <= w_grant | (w_state_nxt == LOCKED);
      o_lock_timeout <= w_to;
      r_last         <= w_grant ? w_sel : r_last;
    end
`ifdef RAW_BUS_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_owner <= (r_state == LOCKED) ? r_owner : w_win;
      r_cnt   <= w_cnt_nxt;
    end
`endif
endmodule

// File: tb/tb_raw_bus_arb.sv
// tb_raw_bus_arb: directed checks of reset, round-robin, null target and lock behaviour.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module tb_raw_bus_arb;
  localparam int N  = 4;
  localparam int DW = `DATA_WIDTH;
  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    i_req, i_lock, o_gnt;
  logic [2*N-1:0]  i_target;
  logic [N*DW-1:0] i_data;
  logic            o_raw_bus_0_en, o_raw_bus_1_en, o_busy, o_lock_timeout;
  logic [DW-1:0]   o_data;
  int              checks = 0;
  int              failures = 0;
  raw_bus_arb #(.N_REQ(N), .LOCK_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n), .i_req(i_req), .i_target(i_target), .i_data(i_data),
    .i_lock(i_lock), .o_gnt(o_gnt), .o_raw_bus_0_en(o_raw_bus_0_en),
    .o_raw_bus_1_en(o_raw_bus_1_en), .o_data(o_data), .o_busy(o_busy),
    .o_lock_timeout(o_lock_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [N-1:0] gnt, input logic en0,
                         input logic en1, input logic [DW-1:0] dat, input logic busy,
                         input logic to);
    chk({tag, ".gnt"}, 64'(o_gnt), 64'(gnt));
    chk({tag, ".en0"}, 64'(o_raw_bus_0_en), 64'(en0));
    chk({tag, ".en1"}, 64'(o_raw_bus_1_en), 64'(en1));
    chk({tag, ".data"}, 64'(o_data), 64'(dat));
    chk({tag, ".busy"}, 64'(o_busy), 64'(busy));
    chk({tag, ".to"}, 64'(o_lock_timeout), 64'(to));
  endtask
  // Asynchronous reset asserted right after a negedge, checked before any clock edge.
  task automatic rst_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk_all(tag, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    i_req = '0; i_lock = '0; i_target = '0; i_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    rst_n = 1'b0; i_req = '0; i_lock = '0; i_target = '0; i_data = '0;
    #3;
    chk_all("reset", '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    i_req = 4'b0100; i_target[5:4] = 2'b11; i_data[2*DW +: DW] = DW'(32'hA5A5_0001);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_all($sformatf("single%0d", c), (c % 2 == 0) ? 4'b0100 : 4'b0000,
              c % 2 == 0, c % 2 == 0, DW'(32'hA5A5_0001), c % 2 == 0, 1'b0);
    end
    rst_pulse("rst_mid_grant");
    i_req = 4'b1111; i_target = 8'b0101_0101;
    for (int k = 0; k < N; k++) i_data[k*DW +: DW] = DW'(32'h10 + k);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_all($sformatf("rr%0d", c), 4'(1 << (c % 4)), 1'b1, 1'b0, DW'(32'h10 + c % 4), 1'b1, 1'b0);
    end
    rst_pulse("rst_rr");
    i_req = 4'b1010; i_target = 8'b1000_0000;
    i_data[1*DW +: DW] = DW'(32'h1111); i_data[3*DW +: DW] = DW'(32'hDEAD);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_all($sformatf("null%0d", c), (c % 2 == 0) ? 4'b1000 : 4'b0000,
              1'b0, c % 2 == 0, DW'(32'hDEAD), c % 2 == 0, 1'b0);
    end
    rst_pulse("rst_null");
    i_req = 4'b0011; i_lock = 4'b0001; i_target = 8'b0000_0101;
    i_data[0 +: DW] = DW'(32'h100); i_data[DW +: DW] = DW'(32'h101);
`ifdef RAW_BUS_ARB_LOCK_EN
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_all($sformatf("lock%0d", c), 4'b0001, 1'b1, 1'b0, DW'(32'h100), 1'b1, 1'b0);
    end
    @(negedge clk);
    chk_all("lock_timeout", 4'b0000, 1'b0, 1'b0, DW'(32'h100), 1'b0, 1'b1);
    @(negedge clk);
    chk_all("lock_next", 4'b0010, 1'b1, 1'b0, DW'(32'h101), 1'b1, 1'b0);
`else
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_all($sformatf("nolock%0d", c), (c % 2 == 0) ? 4'b0001 : 4'b0010, 1'b1, 1'b0,
              (c % 2 == 0) ? DW'(32'h100) : DW'(32'h101), 1'b1, 1'b0);
    end
`endif
    i_req = '0;
    @(negedge clk);
    @(negedge clk);
    chk_all("idle_hold", 4'b0000, 1'b0, 1'b0,
`ifdef RAW_BUS_ARB_LOCK_EN
            DW'(32'h101),
`else
            DW'(32'h100),
`endif
            1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
